mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_responder_word_ram.sv | 27 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default widths, FSM states,
// latency bounds and the instruction field layout shared with the processor.
package mem_responder_pkg;

    localparam int unsigned WORD_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Instruction word field positions used by the processor decoder
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS_MSB  = 8;
    localparam int unsigned RS_LSB  = 6;
    localparam int unsigned IMM_MSB = 5;
    localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port synchronous word array with registered read; contents are not reset.
module word_ram #(
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory target: accepts one request at a time, performs the array
// access LATENCY edges after accept and holds the response until taken.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = WORD_W_DEF,
    parameter int unsigned MEM_WORDS = 65536,
    parameter int unsigned LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 1..15");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_rd_q;
    logic              in_range_c;
    logic              ram_en_c;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready  = (state == IDLE) & ~halt & reset;
    assign in_range_c = 32'(addr_q) < 32'(MEM_WORDS);
    assign ram_en_c   = (state == BUSY) && (cnt == '0) && in_range_c;

    // Read data comes straight from the RAM output register, zeroed for writes and errors
    assign rsp_rdata  = rsp_rd_q ? ram_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~in_range_c;
                        rsp_rd_q  <= in_range_c & ~we_q;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rd_q  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    word_ram #(
        .DEPTH  (MEM_WORDS),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (we_q),
        .addr  (RAM_AW'(addr_q)),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut_a (LATENCY=1, full 64K array) and dut_b (LATENCY=3, 256 words).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        halt_a, req_valid_a, req_ready_a, req_we_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
    logic [15:0] req_addr_a, req_wdata_a, rsp_rdata_a;
    logic        halt_b, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
    logic [15:0] req_addr_b, req_wdata_b, rsp_rdata_b;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(65536), .LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .halt(halt_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(256), .LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .halt(halt_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int d, input logic v, input logic we,
                           input logic [15:0] a, input logic [15:0] w);
        if (d == 0) begin
            req_valid_a = v; req_we_a = we; req_addr_a = a; req_wdata_a = w;
        end else begin
            req_valid_b = v; req_we_b = we; req_addr_b = a; req_wdata_b = w;
        end
    endtask

    task automatic set_halt(input int d, input logic h);
        if (d == 0) halt_a = h; else halt_b = h;
    endtask

    task automatic set_rsp_ready(input int d, input logic r);
        if (d == 0) rsp_ready_a = r; else rsp_ready_b = r;
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? req_ready_a : req_ready_b;
    endfunction

    function automatic logic get_valid(input int d);
        return (d == 0) ? rsp_valid_a : rsp_valid_b;
    endfunction

    function automatic logic [15:0] get_rdata(input int d);
        return (d == 0) ? rsp_rdata_a : rsp_rdata_b;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? rsp_err_a : rsp_err_b;
    endfunction

    // Present a request, let it be accepted, then count edges until rsp_valid
    task automatic issue(input int d, input logic we, input logic [15:0] a,
                         input logic [15:0] w, input logic halt_after, output int lat);
        int n;
        n = 0;
        set_req(d, 1'b1, we, a, w);
        while (!get_ready(d) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        set_req(d, 1'b0, 1'b0, 16'h0, 16'h0);
        if (halt_after) set_halt(d, 1'b1);
        lat = 0;
        while (!get_valid(d) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic complete(input int d);
        set_rsp_ready(d, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(d, 1'b0);
    endtask

    task automatic txn(input int d, input logic we, input logic [15:0] a, input logic [15:0] w,
                       output logic [15:0] rd, output logic er, output int lat);
        issue(d, we, a, w, 1'b0, lat);
        rd = get_rdata(d);
        er = get_err(d);
        complete(d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;

        halt_a = 1'b0; rsp_ready_a = 1'b0;
        halt_b = 1'b0; rsp_ready_b = 1'b0;
        set_req(0, 1'b1, 1'b1, 16'h0010, 16'hDEAD);
        set_req(1, 1'b1, 1'b1, 16'h0010, 16'hDEAD);

        // Reset held with requests pending: nothing may be accepted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_req_ready_a", 32'(req_ready_a), 32'd0);
            check("rst_req_ready_b", 32'(req_ready_b), 32'd0);
            check("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        end
        check("rst_rdata_a", 32'(rsp_rdata_a), 32'd0);
        check("rst_err_b", 32'(rsp_err_b), 32'd0);
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk) reset = 1'b1;
        #1;
        check("rel_req_ready_a", 32'(req_ready_a), 32'd1);
        check("rel_req_ready_b", 32'(req_ready_b), 32'd1);
        @(posedge clk); #1;
        check("rel_no_accept_a", 32'(req_ready_a), 32'd1);
        check("rel_no_rsp_b", 32'(rsp_valid_b), 32'd0);

        // LATENCY=1 write then read-back
        txn(0, 1'b1, 16'h0010, 16'hBEEF, rd, er, lat);
        check("a_wr_rdata", 32'(rd), 32'h0);
        check("a_wr_err", 32'(er), 32'd0);
        check("a_wr_lat", 32'(lat), 32'd1);
        txn(0, 1'b0, 16'h0010, 16'h0, rd, er, lat);
        check("a_rd_rdata", 32'(rd), 32'hBEEF);
        check("a_rd_err", 32'(er), 32'd0);
        check("a_rd_lat", 32'(lat), 32'd1);
        check("a_idle_after", 32'(req_ready_a), 32'd1);
        txn(0, 1'b1, 16'hFFFF, 16'h0A5A, rd, er, lat);
        check("a_top_wr_err", 32'(er), 32'd0);
        txn(0, 1'b0, 16'hFFFF, 16'h0, rd, er, lat);
        check("a_top_rd_rdata", 32'(rd), 32'h0A5A);
        check("a_top_rd_err", 32'(er), 32'd0);

        // LATENCY=3 response held while rsp_ready stays low
        txn(1, 1'b1, 16'h0042, 16'h7777, rd, er, lat);
        check("b_wr_lat", 32'(lat), 32'd3);
        issue(1, 1'b0, 16'h0042, 16'h0, 1'b0, lat);
        check("b_rd_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("b_hold_valid", 32'(rsp_valid_b), 32'd1);
            check("b_hold_rdata", 32'(rsp_rdata_b), 32'h7777);
            check("b_hold_err", 32'(rsp_err_b), 32'd0);
            check("b_hold_ready", 32'(req_ready_b), 32'd0);
            @(posedge clk); #1;
        end
        complete(1);
        check("b_release_valid", 32'(rsp_valid_b), 32'd0);
        check("b_release_ready", 32'(req_ready_b), 32'd1);

        // Range boundary at 256 words; out-of-range write must not alias to word 0
        txn(1, 1'b1, 16'h0000, 16'h0101, rd, er, lat);
        txn(1, 1'b1, 16'h00FF, 16'h3C3C, rd, er, lat);
        check("b_ff_wr_err", 32'(er), 32'd0);
        txn(1, 1'b1, 16'h0100, 16'h1234, rd, er, lat);
        check("b_oor_wr_err", 32'(er), 32'd1);
        check("b_oor_wr_rdata", 32'(rd), 32'h0);
        txn(1, 1'b0, 16'h00FF, 16'h0, rd, er, lat);
        check("b_ff_rd_rdata", 32'(rd), 32'h3C3C);
        check("b_ff_rd_err", 32'(er), 32'd0);
        txn(1, 1'b0, 16'h0100, 16'h0, rd, er, lat);
        check("b_oor_rd_rdata", 32'(rd), 32'h0);
        check("b_oor_rd_err", 32'(er), 32'd1);
        txn(1, 1'b0, 16'h0000, 16'h0, rd, er, lat);
        check("b_zero_no_alias", 32'(rd), 32'h0101);

        // halt raised right after the accept edge of a read
        issue(1, 1'b0, 16'h0042, 16'h0, 1'b1, lat);
        check("halt_lat", 32'(lat), 32'd3);
        check("halt_rdata", 32'(rsp_rdata_b), 32'h7777);
        check("halt_ready_busy", 32'(req_ready_b), 32'd0);
        complete(1);
        check("halt_rsp_done", 32'(rsp_valid_b), 32'd0);
        set_req(1, 1'b1, 1'b0, 16'h0042, 16'h0);
        for (int i = 0; i < 2; i++) begin
            check("halt_ready_idle", 32'(req_ready_b), 32'd0);
            @(posedge clk); #1;
        end
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        check("halt_no_accept", 32'(rsp_valid_b), 32'd0);
        set_halt(1, 1'b0);
        #1;
        check("halt_release_ready", 32'(req_ready_b), 32'd1);

        // Reset during BUSY discards a pending write
        txn(1, 1'b1, 16'h0020, 16'h0001, rd, er, lat);
        set_req(1, 1'b1, 1'b1, 16'h0020, 16'h5555);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("busy_before_rst", 32'(req_ready_b), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rsp_valid_b), 32'd0);
        check("rst_mid_ready", 32'(req_ready_b), 32'd0);
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        check("rst_mid_idle", 32'(req_ready_b), 32'd1);
        @(posedge clk); #1;
        check("rst_mid_no_rsp", 32'(rsp_valid_b), 32'd0);
        txn(1, 1'b0, 16'h0020, 16'h0, rd, er, lat);
        check("rst_mid_old_data", 32'(rd), 32'h0001);
        txn(0, 1'b0, 16'h0010, 16'h0, rd, er, lat);
        check("a_array_kept", 32'(rd), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
